// File: rtl/vga_bar_gen.sv
// VGA 640x480@60 timing generator with an eight-bar colour test pattern.
// Runs from the 100 MHz oscillator using an internal 25 MHz pixel enable.
module vga_bar_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CLK_DIV   = 4,
    parameter int BAR_WIDTH = 80
) (
    input  logic       CLK_100MHz,
    input  logic       RST,
    output logic       HSync,
    output logic       VSync,
    output logic [2:0] Red,
    output logic [2:0] Green,
    output logic [1:0] Blue
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int PS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW_W = (BAR_WIDTH > 1) ? $clog2(BAR_WIDTH) : 1;

    localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLK_DIV - 1);
    localparam logic [BW_W-1:0] BAR_MAX = BW_W'(BAR_WIDTH - 1);
    localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT = 10'(H_VISIBLE);
    localparam logic [9:0] V_ACT = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [PS_W-1:0] prescaler;
    logic [9:0]      h_cnt;
    logic [9:0]      v_cnt;
    logic [BW_W-1:0] bar_px;
    logic [2:0]      bar_idx;

    logic       pix_en;
    logic       h_wrap;
    logic       v_wrap;
    logic       bar_last;
    logic       active;
    logic       hs_next;
    logic       vs_next;
    logic [2:0] red_next;
    logic [2:0] green_next;
    logic [1:0] blue_next;

    always_comb begin
        pix_en   = (prescaler == PS_MAX);
        h_wrap   = (h_cnt == H_MAX);
        v_wrap   = (v_cnt == V_MAX);
        bar_last = (bar_px == BAR_MAX);
    end

    // Decode the pixel currently addressed by the counters; the output
    // registers capture it, so the pins lag the counters by one pixel.
    always_comb begin
        active     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_next    = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
        vs_next    = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
        red_next   = 3'b000;
        green_next = 3'b000;
        blue_next  = 2'b00;
        if (active) begin
            red_next   = {3{bar_idx[2]}};
            green_next = {3{bar_idx[1]}};
            blue_next  = {2{bar_idx[0]}};
        end
    end

    always_ff @(posedge CLK_100MHz or posedge RST) begin
        if (RST) begin
            prescaler <= '0;
        end else if (pix_en) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    always_ff @(posedge CLK_100MHz or posedge RST) begin
        if (RST) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Bar counter tracks h_cnt / BAR_WIDTH without a divider.
    always_ff @(posedge CLK_100MHz or posedge RST) begin
        if (RST) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (pix_en) begin
            if (h_wrap) begin
                bar_px  <= '0;
                bar_idx <= '0;
            end else if (bar_last) begin
                bar_px  <= '0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_px <= bar_px + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_100MHz or posedge RST) begin
        if (RST) begin
            HSync <= 1'b1;
            VSync <= 1'b1;
            Red   <= '0;
            Green <= '0;
            Blue  <= '0;
        end else if (pix_en) begin
            HSync <= hs_next;
            VSync <= vs_next;
            Red   <= red_next;
            Green <= green_next;
            Blue  <= blue_next;
        end
    end

endmodule

// File: tb/tb_vga_bar_gen.sv
// Bench for vga_bar_gen: full-size timing plus a shrunk raster for frame
// wrap and vsync, both compared pixel-by-pixel against an arithmetic model.
`timescale 1ns/1ps
module tb_vga_bar_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       hs_b, vs_b;
    logic [2:0] r_b, g_b;
    logic [1:0] bl_b;
    logic       hs_s, vs_s;
    logic [2:0] r_s, g_s;
    logic [1:0] bl_s;

    int checks = 0;
    int failures = 0;
    int k = 0;

    vga_bar_gen dut (
        .CLK_100MHz(clk),
        .RST       (rst),
        .HSync     (hs_b),
        .VSync     (vs_b),
        .Red       (r_b),
        .Green     (g_b),
        .Blue      (bl_b)
    );

    vga_bar_gen #(
        .H_VISIBLE(32), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_VISIBLE(6),  .V_FP(2), .V_SYNC(1), .V_BP(2),
        .CLK_DIV(4),    .BAR_WIDTH(4)
    ) dut_s (
        .CLK_100MHz(clk),
        .RST       (rst),
        .HSync     (hs_s),
        .VSync     (vs_s),
        .Red       (r_s),
        .Green     (g_s),
        .Blue      (bl_s)
    );

    // n = pixel updates since reset release; update n shows raster pixel n-1.
    function automatic logic [9:0] model(
        input int n,
        input int hv, input int hfp, input int hsy, input int hbp,
        input int vv, input int vfp, input int vsy, input int vbp,
        input int bw
    );
        int ht, vt, p, h, v, b;
        logic hs, vs;
        logic [2:0] r, g;
        logic [1:0] bb;
        if (n == 0) return 10'b11_000_000_00;
        ht = hv + hfp + hsy + hbp;
        vt = vv + vfp + vsy + vbp;
        p  = n - 1;
        h  = p % ht;
        v  = (p / ht) % vt;
        hs = !(h >= hv + hfp && h < hv + hfp + hsy);
        vs = !(v >= vv + vfp && v < vv + vfp + vsy);
        r  = 3'b000;
        g  = 3'b000;
        bb = 2'b00;
        if (h < hv && v < vv) begin
            b  = h / bw;
            r  = ((b & 4) != 0) ? 3'b111 : 3'b000;
            g  = ((b & 2) != 0) ? 3'b111 : 3'b000;
            bb = ((b & 1) != 0) ? 2'b11 : 2'b00;
        end
        return {hs, vs, r, g, bb};
    endfunction

    task automatic check_eq(input string tag, input logic [9:0] got,
                            input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic check_all(input string when);
        check_eq($sformatf("big_%s k=%0d", when, k),
                 {hs_b, vs_b, r_b, g_b, bl_b},
                 model(k / 4, 640, 16, 96, 48, 480, 10, 2, 33, 80));
        check_eq($sformatf("small_%s k=%0d", when, k),
                 {hs_s, vs_s, r_s, g_s, bl_s},
                 model(k / 4, 32, 2, 4, 3, 6, 2, 1, 2, 4));
    endtask

    task automatic run(input int cyc);
        repeat (cyc) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            check_all("run");
        end
    endtask

    task automatic hold(input int cyc);
        repeat (cyc) begin
            @(negedge clk);
            check_all("rst");
        end
    endtask

    initial begin
        rst = 1'b1;
        k = 0;
        hold(10);
        rst = 1'b0;
        run(4000);
        for (int i = 0; i < 3; i++) begin
            #($urandom_range(1, 3));
            rst = 1'b1;
            k = 0;
            #1;
            check_all("async");
            hold($urandom_range(2, 6));
            rst = 1'b0;
            run($urandom_range(600, 3000));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
